// File: rtl/regfile_wb_arbiter.sv
// Write-port controller for the GPR file: zero-fills every register after
// reset, then shares the single write port between requester A (EXU) and
// requester B (LSU) with round-robin arbitration. Writes to x0 are dropped.
module regfile_wb_arbiter #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_valid,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_data,
    output logic                  a_ready,
    input  logic                  b_valid,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_data,
    output logic                  b_ready,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  init_done
);

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    localparam logic [ADDR_WIDTH-1:0] CNT_LAST = '1;
    localparam logic                  GRANT_A  = 1'b0;
    localparam logic                  GRANT_B  = 1'b1;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q;
    logic                    last_grant_q;
    logic                    wb_v_q;
    logic [ADDR_WIDTH-1:0]   wb_addr_q;
    logic [DATA_WIDTH-1:0]   wb_data_q;
    logic                    init_done_q;
    logic                    a_fire;
    logic                    b_fire;

    assign a_fire    = a_valid & a_ready;
    assign b_fire    = b_valid & b_ready;
    assign init_done = init_done_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: leave INIT after the last zero-fill write; RUN is sticky
    always_comb begin
        state_d = state_q;
        if ((state_q == S_INIT) && (cnt_q == CNT_LAST)) begin
            state_d = S_RUN;
        end
    end

    // Outputs: zero-fill drive in INIT, write stage + arbitration in RUN
    always_comb begin
        a_ready  = 1'b0;
        b_ready  = 1'b0;
        rf_wen   = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        if (state_q == S_INIT) begin
            rf_wen   = !rst;
            rf_waddr = cnt_q;
            rf_wdata = '0;
        end else begin
            a_ready  = !rst && (!b_valid || (last_grant_q == GRANT_B));
            b_ready  = !rst && (!a_valid || (last_grant_q == GRANT_A));
            rf_wen   = wb_v_q && !rst;
            rf_waddr = wb_addr_q;
            rf_wdata = wb_data_q;
        end
    end

    // Zero-fill counter and registered init_done flag
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            init_done_q <= 1'b0;
        end else begin
            if (state_q == S_INIT) begin
                cnt_q <= cnt_q + ADDR_WIDTH'(1);
            end
            init_done_q <= (state_d == S_RUN);
        end
    end

    // Write stage capture and round-robin pointer update
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= GRANT_B;
            wb_v_q       <= 1'b0;
            wb_addr_q    <= '0;
            wb_data_q    <= '0;
        end else if (a_fire) begin
            last_grant_q <= GRANT_A;
            wb_v_q       <= (a_addr != '0);
            wb_addr_q    <= a_addr;
            wb_data_q    <= a_data;
        end else if (b_fire) begin
            last_grant_q <= GRANT_B;
            wb_v_q       <= (b_addr != '0);
            wb_addr_q    <= b_addr;
            wb_data_q    <= b_data;
        end else begin
            wb_v_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: zero-fill, single writes, x0 drop,
// round-robin contention, back-to-back writes and reset mid-writeback.
module tb_regfile_wb_arbiter;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;

    logic          clk;
    logic          rst;
    logic          a_valid;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_data;
    logic          a_ready;
    logic          b_valid;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_data;
    logic          b_ready;
    logic          rf_wen;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          init_done;

    int n_checks;
    int n_errors;

    regfile_wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .a_valid   (a_valid),
        .a_addr    (a_addr),
        .a_data    (a_data),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_addr    (b_addr),
        .b_data    (b_data),
        .b_ready   (b_ready),
        .rf_wen    (rf_wen),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .init_done (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock, land just after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        a_valid  = 1'b1;
        a_addr   = 5'd9;
        a_data   = 32'h99;
        b_valid  = 1'b0;
        b_addr   = '0;
        b_data   = '0;

        // Reset held for two cycles
        step();
        step();
        chk("rst_wen", 64'(rf_wen), 64'd0);
        chk("rst_waddr", 64'(rf_waddr), 64'd0);
        chk("rst_wdata", 64'(rf_wdata), 64'd0);
        chk("rst_init_done", 64'(init_done), 64'd0);
        chk("rst_a_ready", 64'(a_ready), 64'd0);
        chk("rst_b_ready", 64'(b_ready), 64'd0);

        // Zero-fill: register k written in cycle k, no ready despite a_valid
        rst = 1'b0;
        for (int k = 0; k < 32; k++) begin
            a_valid = (k < 31);
            #1;
            chk("fill_wen", 64'(rf_wen), 64'd1);
            chk("fill_waddr", 64'(rf_waddr), 64'(k));
            chk("fill_wdata", 64'(rf_wdata), 64'd0);
            chk("fill_a_ready", 64'(a_ready), 64'd0);
            chk("fill_init_done", 64'(init_done), 64'd0);
            step();
        end
        a_valid = 1'b0;
        #1;
        chk("init_done_32", 64'(init_done), 64'd1);
        chk("idle_wen", 64'(rf_wen), 64'd0);

        // Single A write to x5
        a_valid = 1'b1;
        a_addr  = 5'd5;
        a_data  = 32'hDEADBEEF;
        #1;
        chk("a5_a_ready", 64'(a_ready), 64'd1);
        chk("a5_b_ready", 64'(b_ready), 64'd0);
        step();
        a_valid = 1'b0;
        #1;
        chk("a5_wen", 64'(rf_wen), 64'd1);
        chk("a5_waddr", 64'(rf_waddr), 64'd5);
        chk("a5_wdata", 64'(rf_wdata), 64'hDEADBEEF);
        step();
        chk("a5_wen_after", 64'(rf_wen), 64'd0);

        // B write to x0: handshake completes, no register write
        b_valid = 1'b1;
        b_addr  = 5'd0;
        b_data  = 32'hFFFFFFFF;
        #1;
        chk("bx0_b_ready", 64'(b_ready), 64'd1);
        step();
        b_valid = 1'b0;
        #1;
        chk("bx0_wen", 64'(rf_wen), 64'd0);
        step();

        // Contention: last grant was B, so A wins first, then alternate
        a_valid = 1'b1; a_addr = 5'd1; a_data = 32'h11;
        b_valid = 1'b1; b_addr = 5'd2; b_data = 32'h22;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_a_ready", 64'(a_ready), 64'((i % 2) == 0));
            chk("rr_b_ready", 64'(b_ready), 64'((i % 2) == 1));
            if (i > 0) begin
                chk("rr_wen", 64'(rf_wen), 64'd1);
                chk("rr_waddr", 64'(rf_waddr), ((i % 2) == 1) ? 64'd1 : 64'd2);
                chk("rr_wdata", 64'(rf_wdata), ((i % 2) == 1) ? 64'h11 : 64'h22);
            end
            step();
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        #1;
        chk("rr_last_wen", 64'(rf_wen), 64'd1);
        chk("rr_last_waddr", 64'(rf_waddr), 64'd2);
        chk("rr_last_wdata", 64'(rf_wdata), 64'h22);
        step();

        // B back-to-back to x3, x4, x5
        for (int i = 0; i < 3; i++) begin
            b_valid = 1'b1;
            b_addr  = AW'(3 + i);
            b_data  = DW'(32'h30 + i);
            #1;
            chk("bb_b_ready", 64'(b_ready), 64'd1);
            if (i > 0) begin
                chk("bb_wen", 64'(rf_wen), 64'd1);
                chk("bb_waddr", 64'(rf_waddr), 64'(2 + i));
                chk("bb_wdata", 64'(rf_wdata), 64'(32'h2F + i));
            end
            step();
        end
        b_valid = 1'b0;
        #1;
        chk("bb_last_wen", 64'(rf_wen), 64'd1);
        chk("bb_last_waddr", 64'(rf_waddr), 64'd5);
        chk("bb_last_wdata", 64'(rf_wdata), 64'h32);
        step();
        chk("bb_idle_wen", 64'(rf_wen), 64'd0);

        // Transfer A x7 at edge N, reset sampled at edge N+1
        a_valid = 1'b1;
        a_addr  = 5'd7;
        a_data  = 32'h77;
        #1;
        chk("a7_a_ready", 64'(a_ready), 64'd1);
        step();
        a_valid = 1'b0;
        rst     = 1'b1;
        #1;
        chk("a7_wen_dropped", 64'(rf_wen), 64'd0);
        chk("a7_a_ready_rst", 64'(a_ready), 64'd0);
        step();
        chk("rst2_init_done", 64'(init_done), 64'd0);
        chk("rst2_wen", 64'(rf_wen), 64'd0);
        rst = 1'b0;
        #1;
        chk("refill_wen0", 64'(rf_wen), 64'd1);
        chk("refill_waddr0", 64'(rf_waddr), 64'd0);
        chk("refill_wdata0", 64'(rf_wdata), 64'd0);
        step();
        chk("refill_waddr1", 64'(rf_waddr), 64'd1);
        chk("refill_init_done", 64'(init_done), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
